// File: rtl/data_memory_pkg.sv
// Shared constants and word types for the RISC-V data memory and datapath.
package data_memory_pkg;

    localparam int ADDR_WIDTH = 10;
    localparam int DATA_WIDTH = 64;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/data_memory.sv
// Word-addressed single-port data memory: synchronous write, registered read,
// asynchronous reset restores the identity preload image (word i holds i).
module data_memory
    import data_memory_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  memwrite,
    input  logic                  memread,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data
);

    data_t mem [DEPTH];

    // NOTE: the array is reset on purpose (deterministic preload image), which
    // rules out block-RAM mapping; this memory is implemented in flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            read_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= data_t'(i);
            end
        end else begin
            // Both updates are non-blocking, so a same-address read sees the old word.
            if (memread) begin
                read_data <= mem[address];
            end
            if (memwrite) begin
                mem[address] <= write_data;
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed plan plus randomized traffic
// compared against an array-based reference model.
module tb_data_memory;

    logic        clock;
    logic        reset;
    logic        memwrite;
    logic        memread;
    logic [9:0]  address;
    logic [63:0] write_data;
    logic [63:0] read_data;

    logic [63:0] model [1024];
    logic [63:0] exp_rd;
    int          n_compared;
    int          n_mismatched;

    data_memory dut (
        .clock      (clock),
        .reset      (reset),
        .memwrite   (memwrite),
        .memread    (memread),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Reference reset: identity image, read register cleared.
    task automatic model_reset();
        for (int i = 0; i < 1024; i++) model[i] = 64'(i);
        exp_rd = '0;
    endtask

    // One clock cycle of traffic; checks read_data just after the edge.
    task automatic cycle(input logic we, input logic re, input logic [9:0] a,
                         input logic [63:0] wd, input string tag);
        memwrite   = we;
        memread    = re;
        address    = a;
        write_data = wd;
        @(posedge clock);
        if (re) exp_rd = model[a];
        if (we) model[a] = wd;
        #1 check(tag, read_data, exp_rd);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        model_reset();

        // Reset held for two edges with a write attempted: it must be ignored.
        reset      = 1'b0;
        memwrite   = 1'b1;
        memread    = 1'b1;
        address    = 10'd10;
        write_data = 64'hDEAD_BEEF_DEAD_BEEF;
        #1 check("reset_async", read_data, 64'h0);
        repeat (2) begin
            @(posedge clock);
            #1 check("reset_hold", read_data, 64'h0);
        end
        reset = 1'b1;

        cycle(0, 1, 10'd10, '0, "preload_10");
        check("preload_10_const", read_data, 64'h000000000000000A);

        cycle(1, 0, 10'd50, 64'hAAAAAAAAAAAAAAAA, "wr_50");
        cycle(0, 1, 10'd50, '0, "rd_50");
        check("rd_50_const", read_data, 64'hAAAAAAAAAAAAAAAA);
        cycle(1, 0, 10'd100, 64'hF0F0F0F0F0F0F0F0, "wr_100");
        cycle(0, 1, 10'd100, '0, "rd_100");
        cycle(0, 1, 10'd50, '0, "rerd_50");

        // Same-address read and write: old word out, new word stored.
        cycle(1, 1, 10'd50, 64'h1, "rbw_50");
        check("rbw_50_const", read_data, 64'hAAAAAAAAAAAAAAAA);
        cycle(0, 1, 10'd50, '0, "after_rbw_50");
        check("after_rbw_50_const", read_data, 64'h1);

        // Hold: read 100, then idle with the address moving.
        cycle(0, 1, 10'd100, '0, "rd_100_again");
        cycle(0, 0, 10'd10, '0, "hold_idle");
        check("hold_const", read_data, 64'hF0F0F0F0F0F0F0F0);
        cycle(1, 0, 10'd10, 64'h1234, "hold_wr");

        // Different-address read and write in one cycle.
        cycle(1, 1, 10'd7, 64'h5555_0000_5555_0000, "rw_diff_a");
        cycle(1, 1, 10'd200, 64'h77, "rw_diff_b");
        cycle(0, 1, 10'd7, '0, "rw_diff_c");

        // Address boundaries.
        cycle(1, 0, 10'd0, 64'hFFFF_FFFF_FFFF_FFFF, "wr_0");
        cycle(1, 0, 10'd1023, 64'h0123_4567_89AB_CDEF, "wr_1023");
        cycle(0, 1, 10'd0, '0, "rd_0");
        cycle(0, 1, 10'd1023, '0, "rd_1023");
        check("rd_1023_const", read_data, 64'h0123_4567_89AB_CDEF);
        cycle(0, 1, 10'd1022, '0, "rd_1022_preload");

        // Asynchronous reset mid-cycle discards all writes.
        #2 reset = 1'b0;
        model_reset();
        #1 check("mid_reset_async", read_data, 64'h0);
        memwrite = 1'b1;
        memread  = 1'b1;
        address  = 10'd50;
        @(posedge clock);
        #1 check("mid_reset_hold", read_data, 64'h0);
        #2 reset = 1'b1;
        cycle(0, 1, 10'd50, '0, "post_reset_50");
        check("post_reset_50_const", read_data, 64'h0000000000000032);
        cycle(0, 1, 10'd1023, '0, "post_reset_1023");
        cycle(0, 1, 10'd0, '0, "post_reset_0");

        // Randomized traffic, biased toward a few hot addresses for collisions.
        for (int n = 0; n < 800; n++) begin
            logic [9:0]  a;
            logic [63:0] d;
            logic        we;
            logic        re;
            a  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 7))
                                             : 10'($urandom_range(0, 1023));
            d  = {$urandom, $urandom};
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            cycle(we, re, a, d, "random");
        end

        // Random reset, then random reads against the restored preload image.
        #2 reset = 1'b0;
        model_reset();
        #1 check("rand_reset_async", read_data, 64'h0);
        @(posedge clock);
        #2 reset = 1'b1;
        for (int n = 0; n < 50; n++) begin
            cycle(0, 1, 10'($urandom_range(0, 1023)), '0, "random_preload");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
